// File: rtl/fn_arb_pkg.sv
// Shared constants for the round-robin function-unit arbiter.
// Defaults, index width helper and the f truth table.
package fn_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int CNT_W_DEF = 16;

  // f = x | (~y & z), indexed by {x,y,z}
  localparam logic [7:0] FN_TRUTH = 8'b1111_0010;

  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fn_arb_if.sv
// Requester-side bundle for fn_unit_rr_arbiter.
// master = requesters/observer, slave = arbiter.
interface fn_arb_if
  import fn_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  localparam int PTR_W = ptr_w(NREQ);

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  op_x;
  logic [NREQ-1:0]  op_y;
  logic [NREQ-1:0]  op_z;
  logic             hold;
  logic [NREQ-1:0]  gnt;
  logic             rsp_valid;
  logic [PTR_W-1:0] rsp_id;
  logic             rsp_f;
  logic             busy;
  logic [CNT_W-1:0] eval_cnt;

  modport master (
    output req, op_x, op_y, op_z, hold,
    input  gnt, rsp_valid, rsp_id, rsp_f, busy, eval_cnt
  );

  modport slave (
    input  req, op_x, op_y, op_z, hold,
    output gnt, rsp_valid, rsp_id, rsp_f, busy, eval_cnt
  );

endinterface

// File: rtl/fn_unit.sv
// Shared three-input function unit: f = x | (~y & z).
// Ports: x_i, y_i, z_i operands; f_o result.
module fn_unit (
  input  logic x_i,
  input  logic y_i,
  input  logic z_i,
  output logic f_o
);

  assign f_o = x_i | (~y_i & z_i);

endmodule

// File: rtl/fn_unit_rr_arbiter_rr_pick.sv
// Round-robin pick: first set bit of elig after last_winner.
// Ports: elig_i, last_i in; found_o, winner_o out.
module rr_pick
  import fn_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int PTR_W = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0]  elig_i,
  input  logic [PTR_W-1:0] last_i,
  output logic             found_o,
  output logic [PTR_W-1:0] winner_o
);

  int               s;
  logic [PTR_W-1:0] ix;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    s        = 0;
    ix       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      s = int'(last_i) + k;
      if (s >= NREQ) s = s - NREQ;
      ix = PTR_W'(s);
      if (elig_i[ix]) begin
        found_o  = 1'b1;
        winner_o = ix;
      end
    end
  end

endmodule

// File: rtl/fn_unit_rr_arbiter.sv
// Shares one fn_unit among NREQ requesters, round-robin, 2-stage.
// Ports: clk, rst_n; bus (slave) carries req/ops/hold and gnt/rsp/busy/cnt.
module fn_unit_rr_arbiter
  import fn_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  fn_arb_if.slave  bus
);

  localparam int PTR_W = ptr_w(NREQ);
  localparam logic [PTR_W-1:0] LW_RST  = PTR_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREQ-1:0]  gnt_q, gnt_d, elig;
  logic [PTR_W-1:0] lw_q, lw_d, win;
  logic             found;
  logic             opx_q, opy_q, opz_q;
  logic             opx_d, opy_d, opz_d;
  logic             s1_vld_q, s1_vld_d;
  logic [PTR_W-1:0] s1_id_q, s1_id_d;
  logic             rsp_vld_q;
  logic [PTR_W-1:0] rsp_id_q;
  logic             rsp_f_q, f_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Current grantee is masked: no back-to-back grant to one requester.
  assign elig = bus.req & ~gnt_q;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .elig_i   (elig),
    .last_i   (lw_q),
    .found_o  (found),
    .winner_o (win)
  );

  fn_unit u_fn (
    .x_i (opx_q),
    .y_i (opy_q),
    .z_i (opz_q),
    .f_o (f_w)
  );

  always_comb begin
    gnt_d    = '0;
    lw_d     = lw_q;
    opx_d    = opx_q;
    opy_d    = opy_q;
    opz_d    = opz_q;
    s1_vld_d = 1'b0;
    s1_id_d  = s1_id_q;
    if (!bus.hold && found) begin
      gnt_d[win] = 1'b1;
      lw_d       = win;
      opx_d      = bus.op_x[win];
      opy_d      = bus.op_y[win];
      opz_d      = bus.op_z[win];
      s1_vld_d   = 1'b1;
      s1_id_d    = win;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (rsp_vld_q && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      lw_q      <= LW_RST;
      opx_q     <= 1'b0;
      opy_q     <= 1'b0;
      opz_q     <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_id_q   <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_f_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      gnt_q     <= gnt_d;
      lw_q      <= lw_d;
      opx_q     <= opx_d;
      opy_q     <= opy_d;
      opz_q     <= opz_d;
      s1_vld_q  <= s1_vld_d;
      s1_id_q   <= s1_id_d;
      rsp_vld_q <= s1_vld_q;
      rsp_id_q  <= s1_id_q;
      rsp_f_q   <= f_w;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_f     = rsp_f_q;
  assign bus.busy      = (|gnt_q) | rsp_vld_q;
  assign bus.eval_cnt  = cnt_q;

endmodule

// File: tb/tb_fn_unit_rr_arbiter.sv
// Self-checking bench for fn_unit_rr_arbiter (NREQ=4).
// Second instance with CNT_W=4 shares stimulus for saturation.
module tb_fn_unit_rr_arbiter;
  import fn_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fn_arb_if #(.NREQ(4), .CNT_W(16)) bus ();
  fn_arb_if #(.NREQ(4), .CNT_W(4))  bus4 ();

  assign bus4.req  = bus.req;
  assign bus4.op_x = bus.op_x;
  assign bus4.op_y = bus.op_y;
  assign bus4.op_z = bus.op_z;
  assign bus4.hold = bus.hold;

  fn_unit_rr_arbiter #(.NREQ(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fn_unit_rr_arbiter #(.NREQ(4), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  // Reference model state
  logic [3:0] m_gnt;
  int         m_lw, m_gid, m_rid, m_cnt, m_cnt4;
  bit         m_gf, m_rv, m_rf;

  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", n, a, e, $time);
    end
  endtask

  task automatic m_reset();
    m_gnt = 4'b0; m_lw = 3; m_gid = 0; m_gf = 1'b0;
    m_rv = 1'b0; m_rid = 0; m_rf = 1'b0;
    m_cnt = 0; m_cnt4 = 0;
  endtask

  // Advance the model across one clock edge using current inputs.
  task automatic m_step();
    logic [3:0] el;
    logic [1:0] ix;
    int         w;
    if (m_rv) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    m_rv  = (m_gnt != 4'b0);
    m_rid = m_gid;
    m_rf  = m_gf;
    el = bus.req & ~m_gnt;
    w  = -1;
    if (!bus.hold) begin
      for (int off = 1; off <= 4; off++) begin
        ix = 2'((m_lw + off) % 4);
        if (w < 0 && el[ix]) w = int'(ix);
      end
    end
    if (w >= 0) begin
      ix    = 2'(w);
      m_gnt = 4'b1 << w;
      m_lw  = w;
      m_gid = w;
      m_gf  = FN_TRUTH[{bus.op_x[ix], bus.op_y[ix], bus.op_z[ix]}];
    end else begin
      m_gnt = 4'b0;
    end
  endtask

  task automatic cmp_model();
    chk("gnt", bus.gnt, m_gnt);
    chk("rsp_valid", bus.rsp_valid, m_rv);
    chk("busy", bus.busy, (m_gnt != 0) || m_rv);
    chk("eval_cnt", bus.eval_cnt, m_cnt);
    chk("eval_cnt4", bus4.eval_cnt, m_cnt4);
    if (m_rv) begin
      chk("rsp_id", bus.rsp_id, m_rid);
      chk("rsp_f", bus.rsp_f, m_rf);
    end
  endtask

  task automatic cyc(input logic [3:0] r, input logic [3:0] x,
                     input logic [3:0] y, input logic [3:0] z,
                     input logic h);
    bus.req = r; bus.op_x = x; bus.op_y = y; bus.op_z = z; bus.hold = h;
    m_step();
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0; bus.op_x = '0; bus.op_y = '0; bus.op_z = '0;
    bus.hold = 1'b0;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_model();
  endtask

  logic [3:0] eg [6];
  bit         ef [4];
  logic [3:0] fg [6];
  logic [3:0] sg [4];

  initial begin
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    ef = '{1'b0, 1'b1, 1'b0, 1'b1};
    fg = '{4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001};
    sg = '{4'b0000, 4'b0001, 4'b0000, 4'b0001};
    @(negedge clk);
    do_reset();

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_cnt", bus.eval_cnt, 0);
      chk("rst_id", bus.rsp_id, 0);
      chk("rst_f", bus.rsp_f, 0);
    end

    // Single requester 0: xyz=001, 011, 100
    cyc(4'b0001, 4'b0, 4'b0, 4'b1, 1'b0);
    chk("s1_gnt", bus.gnt, 1);
    cyc(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("s1_vld", bus.rsp_valid, 1);
    chk("s1_id", bus.rsp_id, 0);
    chk("s1_f", bus.rsp_f, 1);
    cyc(4'b0001, 4'b0, 4'b1, 4'b1, 1'b0);
    chk("s2_gnt", bus.gnt, 1);
    cyc(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("s2_f", bus.rsp_f, 0);
    cyc(4'b0001, 4'b1, 4'b0, 4'b0, 1'b0);
    cyc(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("s3_vld", bus.rsp_valid, 1);
    chk("s3_f", bus.rsp_f, 1);

    // All four requesting: ops 000/001/010/111
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(4'b1111, 4'b1000, 4'b1100, 4'b1010, 1'b0);
      chk("rot_gnt", bus.gnt, eg[i]);
      if (i >= 1 && i <= 4) chk("rot_f", bus.rsp_f, ef[i-1]);
    end
    chk("rot_cnt", bus.eval_cnt, 4);

    // Fairness with mask
    cyc(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    cyc(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(4'b0101, 4'b0, 4'b0, 4'b0, 1'b0);
      chk("fair_gnt", bus.gnt, fg[i]);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0001, 4'b0, 4'b0, 4'b0, 1'b0);
      chk("solo_gnt", bus.gnt, sg[i]);
    end

    // hold after grant to requester 2
    do_reset();
    cyc(4'b0100, 4'b0100, 4'b0, 4'b0, 1'b0);
    chk("h_gnt2", bus.gnt, 4'b0100);
    cyc(4'b1011, 4'b0, 4'b0, 4'b0, 1'b1);
    chk("h_gnt0", bus.gnt, 0);
    chk("h_vld", bus.rsp_valid, 1);
    chk("h_id", bus.rsp_id, 2);
    cyc(4'b1011, 4'b0, 4'b0, 4'b0, 1'b1);
    chk("h_busy", bus.busy, 0);
    cyc(4'b1011, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("h_next", bus.gnt, 4'b1000);

    // Async reset while gnt=0100
    do_reset();
    cyc(4'b0100, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("ar_pre", bus.gnt, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt", bus.gnt, 0);
    chk("ar_vld", bus.rsp_valid, 0);
    m_reset();
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cmp_model();
    cyc(4'b1111, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("ar_first", bus.gnt, 4'b0001);
    chk("ar_norsp", bus.rsp_valid, 0);
    cyc(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("ar_rid", bus.rsp_id, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
          $urandom_range(0, 7) == 0);
    end
    chk("sat_cnt4", bus4.eval_cnt, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fn_unit_rr_arbiter.md
Name: fn_unit_rr_arbiter

Overview:
- Shares one instance of the team's three-input function unit, f = x | (~y & z), between NREQ requesters.
- Uses round-robin arbitration and a two-stage registered pipeline: grant/operand capture, then result.
- Each requester gets a one-cycle grant pulse and later a tagged result.
- A hold input freezes new grants; a saturating counter tracks completed evaluations for debug.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PTR_W, $clog2(NREQ), requester index width (derived; not overridden).
- CNT_W, 16, evaluation counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  request per requester; bit i = requester i.
- op_x  in  NREQ  x operand, bit i from requester i.
- op_y  in  NREQ  y operand, bit i from requester i.
- op_z  in  NREQ  z operand, bit i from requester i.
- hold  in  1  1 = issue no new grants; in-flight work completes.
- gnt  out  NREQ  registered one-hot grant, one-cycle pulse.
- rsp_valid  out  1  result valid, one-cycle pulse.
- rsp_id  out  PTR_W  index of requester owning rsp_f.
- rsp_f  out  1  f(x,y,z) for the granted operands.
- busy  out  1  gnt != 0 or rsp_valid.
- eval_cnt  out  CNT_W  completed evaluations, saturating.

Behaviour:
- Reset (async assert, sync release): gnt=0, rsp_valid=0, rsp_id=0, rsp_f=0, eval_cnt=0, operand regs=0, last_winner=NREQ-1 (requester 0 has first priority).
- Eligible set: elig = req & ~gnt. The currently-granted requester is masked, so a requester that has not yet dropped req cannot receive a back-to-back grant.
- Arbitration at each edge:
  - If hold=0 and elig!=0, the winner is the first set bit of elig scanning last_winner+1, +2, ... modulo NREQ.
  - gnt <= onehot(winner); last_winner <= winner; opx/opy/opz regs <= op_x[winner], op_y[winner], op_z[winner]; stage-1 valid <= 1.
  - Otherwise gnt <= 0, stage-1 valid <= 0, and last_winner is unchanged.
- Result stage: rsp_valid <= stage-1 valid; rsp_id <= stage-1 id; rsp_f <= f(opx_reg, opy_reg, opz_reg), computed by the function unit from the registered operands.
- Latency: req sampled high at edge k -> gnt[i]=1 during cycle k+1 -> rsp_valid=1 with rsp_id=i during cycle k+2.
- Throughput: one grant per cycle when at least two requesters are eligible. A single continuously-requesting requester gets a grant every other cycle.
- Requester contract: operands stable while req=1 until gnt observed; req deasserted (or new operands presented) in the cycle after gnt. Operands are sampled only at the granting edge; changes at any other time are ignored.
- hold: takes effect at the same edge it is sampled. A grant already in gnt still produces its rsp_valid. busy falls 2 cycles after the last grant.
- eval_cnt increments on each rsp_valid edge; it saturates at 2^CNT_W-1 and does not wrap.
- req bits asserted while hold=1 are served after hold drops, in round-robin order from last_winner.
- Reset mid-operation: pending gnt/rsp are discarded with no rsp_valid pulse, and the pointer returns to the reset value.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package fn_arb_pkg: default NREQ and CNT_W, the PTR_W derivation, and constant FN_TRUTH = 8'b1111_0010 (f indexed by {x,y,z}) for the bench.
- One natural sub-module: rr_pick. It is purely combinational: inputs elig and last_winner; outputs found and winner index.
- The function unit is instantiated as-is on the registered operands.

Test Plan:
- Reset release with req=0000: all outputs 0, busy=0, eval_cnt=0 for 10 cycles.
- Single request, req=0001 with {x,y,z}=001 on requester 0: gnt=0001 at k+1; rsp_valid=1, rsp_id=0, rsp_f=1 at k+2. Repeat with 011 -> rsp_f=0 and 100 -> rsp_f=1.
- All four requesting continuously, operands 000/001/010/111: grants rotate 0001,0010,0100,1000,0001...; rsp_f sequence 0,1,0,1; eval_cnt=4 after the first round.
- Fairness with mask, req=0101 held high: grants alternate 0001,0100 every cycle with no repeat. Then req=0001 alone held high: gnt=0001 every second cycle.
- hold=1 asserted the cycle after the grant to requester 2: that result still arrives; no further gnt while hold=1; after hold=0 the next grant goes to requester 3 if req[3]=1.
- Async reset pulsed while gnt=0100: gnt and rsp_valid clear immediately; no response for requester 2; the next grant, with req=1111, goes to requester 0. Separately, force CNT_W=4 and run 20 evaluations: eval_cnt stays at 15.
